// File: rtl/smb_pkg.sv
// Shared types and constants for the store merge buffer.
// Line entries carry the line address, the aligned 128-bit image and its byte-select.
package smb_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int OFF_W       = 4;
    localparam int SMB_ADDR_W  = 16;
    localparam int LINE_ADDR_W = SMB_ADDR_W - OFF_W;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0]  line_addr;
        logic [LINE_BYTES*8-1:0] data;
        logic [LINE_BYTES-1:0]   sel;
    } line_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } smb_state_t;

endpackage

// File: rtl/store_aligner.sv
// Places a byte or halfword store into a line-wide image with its byte-select.
// Misaligned words and unsupported masks are flagged illegal and produce an empty select.
module store_aligner
    import smb_pkg::*;
(
    input  logic [OFF_W-1:0]        off_i,
    input  logic [15:0]             data_i,
    input  logic [1:0]              wmask_i,
    output logic [LINE_BYTES*8-1:0] img_o,
    output logic [LINE_BYTES-1:0]   sel_o,
    output logic                    illegal_o
);

    logic is_byte;
    logic is_word;

    always_comb begin
        is_byte   = (wmask_i == 2'b01);
        is_word   = (wmask_i == 2'b11);
        illegal_o = !(is_byte || (is_word && !off_i[0]));
        img_o     = '0;
        sel_o     = '0;
        if (!illegal_o) begin
            sel_o = (is_word ? LINE_BYTES'(3) : LINE_BYTES'(1)) << off_i;
            img_o = (LINE_BYTES*8)'(is_word ? data_i : {8'h00, data_i[7:0]}) << {off_i, 3'b000};
        end
    end

endmodule

// File: rtl/store_merge_buffer.sv
// Write-combining store buffer: coalesces stores into line entries and drains them in order.
// Also flags line conflicts for a pending load address.
module store_merge_buffer
    import smb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SMB_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [15:0]             st_data,
    input  logic [1:0]              st_wmask,
    output logic                    st_err,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-5:0]       wr_line_addr,
    output logic [LINE_BYTES*8-1:0] wr_data,
    output logic [LINE_BYTES-1:0]   wr_sel,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_conflict,
    input  logic                    flush_req,
    output logic                    flush_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    line_entry_t         ent_q [DEPTH];
    line_entry_t         ent_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, last_idx;
    logic [PTR_W:0]      count_q, count_d;
    smb_state_t          state_q, state_d;
    logic                st_err_q;

    logic [LINE_BYTES*8-1:0] a_img;
    logic [LINE_BYTES-1:0]   a_sel;
    logic                    a_illegal;
    logic merge_hit, st_fire, do_merge, do_alloc, do_drain;
    logic unused_ld_off;

    store_aligner u_align (
        .off_i     (st_addr[OFF_W-1:0]),
        .data_i    (st_data),
        .wmask_i   (st_wmask),
        .img_o     (a_img),
        .sel_o     (a_sel),
        .illegal_o (a_illegal)
    );

    assign unused_ld_off = ^ld_addr[OFF_W-1:0];

    // Only the youngest entry merges, and never while it is also the head on the cache port.
    assign last_idx  = tail_q - 1'b1;
    assign merge_hit = (count_q >= TWO_C) && (ent_q[last_idx].line_addr == st_addr[ADDR_W-1:OFF_W]);
    assign st_ready  = (state_q == RUN) && ((count_q < DEPTH_C) || merge_hit);
    assign st_fire   = st_valid && st_ready;
    assign do_merge  = st_fire && !a_illegal && merge_hit;
    assign do_alloc  = st_fire && !a_illegal && !merge_hit;
    assign do_drain  = wr_valid && wr_ready;

    assign wr_valid     = (count_q != '0);
    assign wr_line_addr = ent_q[head_q].line_addr;
    assign wr_data      = ent_q[head_q].data;
    assign wr_sel       = ent_q[head_q].sel;
    assign st_err       = st_err_q;
    assign flush_done   = (state_q == DONE);

    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((ent_q[i].sel != '0) && (ent_q[i].line_addr == ld_addr[ADDR_W-1:OFF_W]))
                ld_conflict = 1'b1;
        end
    end

    // A cleared select marks a free slot, so drained entries drop out of the conflict check.
    always_comb begin
        ent_d = ent_q;
        if (do_drain)
            ent_d[head_q].sel = '0;
        if (do_merge) begin
            for (int unsigned b = 0; b < LINE_BYTES; b++) begin
                if (a_sel[b])
                    ent_d[last_idx].data[b*8 +: 8] = a_img[b*8 +: 8];
            end
            ent_d[last_idx].sel = ent_q[last_idx].sel | a_sel;
        end
        if (do_alloc) begin
            ent_d[tail_q].line_addr = st_addr[ADDR_W-1:OFF_W];
            ent_d[tail_q].data      = a_img;
            ent_d[tail_q].sel       = a_sel;
        end
        head_d  = head_q + PTR_W'(do_drain);
        tail_d  = tail_q + PTR_W'(do_alloc);
        count_d = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_drain);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req) state_d = FLUSH;
            FLUSH:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            state_q  <= RUN;
            st_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i].sel <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            state_q  <= state_d;
            st_err_q <= st_fire && a_illegal;
            ent_q    <= ent_d;
        end
    end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Self-checking bench for store_merge_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the buffer.
module tb_store_merge_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic         st_ready;
    logic [15:0]  st_addr;
    logic [15:0]  st_data;
    logic [1:0]   st_wmask;
    logic         st_err;
    logic         wr_valid;
    logic         wr_ready;
    logic [11:0]  wr_line_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_sel;
    logic [15:0]  ld_addr;
    logic         ld_conflict;
    logic         flush_req;
    logic         flush_done;

    store_merge_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_wmask     (st_wmask),
        .st_err       (st_err),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_line_addr (wr_line_addr),
        .wr_data      (wr_data),
        .wr_sel       (wr_sel),
        .ld_addr      (ld_addr),
        .ld_conflict  (ld_conflict),
        .flush_req    (flush_req),
        .flush_done   (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an ordered queue of line entries, each a byte array plus select.
    typedef struct {
        logic [11:0]       line;
        logic [15:0][7:0]  bytes;
        logic [15:0]       sel;
    } ment_t;

    ment_t mq[$];
    bit    m_err;
    int    m_mode;  // 0 accepting, 1 flushing, 2 flush complete

    function automatic bit m_hit();
        return (mq.size() >= 2) && (mq[mq.size()-1].line == st_addr[15:4]);
    endfunction

    function automatic bit m_ready();
        return (m_mode == 0) && ((mq.size() < DEPTH) || m_hit());
    endfunction

    function automatic bit m_conflict();
        foreach (mq[i]) if (mq[i].line == ld_addr[15:4]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int    sz;
        int    off;
        bit    fire, hit, ill;
        ment_t e, t;
        sz = mq.size();
        if (!rst_n) begin
            mq.delete();
            m_err  = 1'b0;
            m_mode = 0;
            return;
        end
        fire = st_valid && m_ready();
        hit  = m_hit();
        off  = int'(st_addr[3:0]);
        ill  = !((st_wmask == 2'b01) || (st_wmask == 2'b11 && st_addr[0] == 1'b0));
        if (fire && !ill) begin
            e.line  = st_addr[15:4];
            e.bytes = '0;
            e.sel   = '0;
            e.bytes[off] = st_data[7:0];
            e.sel[off]   = 1'b1;
            if (st_wmask == 2'b11) begin
                e.bytes[off+1] = st_data[15:8];
                e.sel[off+1]   = 1'b1;
            end
            if (hit) begin
                t = mq[mq.size()-1];
                for (int k = 0; k < 16; k++) if (e.sel[k]) t.bytes[k] = e.bytes[k];
                t.sel = t.sel | e.sel;
                mq[mq.size()-1] = t;
            end else begin
                mq.push_back(e);
            end
        end
        if (sz > 0 && wr_ready) void'(mq.pop_front());
        m_err = fire && ill;
        case (m_mode)
            0: if (flush_req) m_mode = 1;
            1: if (sz == 0) m_mode = 2;
            default: m_mode = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_wmask  = 2'b01;
        wr_ready  = 1'b0;
        ld_addr   = '0;
        flush_req = 1'b0;
    endtask

    task automatic push_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_wmask = m;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL reset_st_err got=%b exp=0", st_err); end
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        n_cmp++; if (ld_conflict !== 1'b0) begin n_bad++; $display("FAIL reset_ld_conflict got=%b exp=0", ld_conflict); end
    endtask

    task automatic test_byte_store();
        logic [127:0] exp_data;
        exp_data = '0;
        exp_data[47:40] = 8'hAB;
        wr_ready = 1'b1;
        push_store(16'h1235, 16'h00AB, 2'b01);
        wr_ready = 1'b0;
        ld_addr  = 16'h123F;
        #1;
        n_cmp++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL byte_wr_valid got=%b exp=1", wr_valid); end
        n_cmp++; if (wr_line_addr !== 12'h123) begin n_bad++; $display("FAIL byte_line got=%h exp=123", wr_line_addr); end
        n_cmp++; if (wr_sel !== 16'h0020) begin n_bad++; $display("FAIL byte_sel got=%h exp=0020", wr_sel); end
        n_cmp++; if (wr_data !== exp_data) begin n_bad++; $display("FAIL byte_data got=%h exp=%h", wr_data, exp_data); end
        n_cmp++; if (ld_conflict !== 1'b1) begin n_bad++; $display("FAIL byte_ld_conflict got=%b exp=1", ld_conflict); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        #1;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL byte_drained got=%b exp=0", wr_valid); end
    endtask

    task automatic test_word_store();
        push_store(16'h100E, 16'hBEEF, 2'b11);
        #1;
        n_cmp++; if (wr_sel !== 16'hC000) begin n_bad++; $display("FAIL word_sel got=%h exp=C000", wr_sel); end
        n_cmp++; if (wr_data !== {16'hBEEF, 112'h0}) begin n_bad++; $display("FAIL word_data got=%h", wr_data); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        push_store(16'h100F, 16'h1234, 2'b11);
        #1;
        n_cmp++; if (st_err !== 1'b1) begin n_bad++; $display("FAIL misaligned_err got=%b exp=1", st_err); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL misaligned_wr_valid got=%b exp=0", wr_valid); end
        tick();
        #1;
        n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width got=%b exp=0", st_err); end
        push_store(16'h1002, 16'h5555, 2'b10);
        #1;
        n_cmp++; if (st_err !== 1'b1) begin n_bad++; $display("FAIL mask10_err got=%b exp=1", st_err); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL mask10_wr_valid got=%b exp=0", wr_valid); end
        tick();
    endtask

    task automatic test_merge();
        wr_ready = 1'b0;
        push_store(16'h2000, 16'h0011, 2'b01);
        push_store(16'h3000, 16'h0022, 2'b01);
        push_store(16'h3002, 16'h3344, 2'b11);
        #1;
        n_cmp++; if (wr_line_addr !== 12'h200 || wr_sel !== 16'h0001) begin
            n_bad++; $display("FAIL merge_head got=%h/%h exp=200/0001", wr_line_addr, wr_sel); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        #1;
        n_cmp++; if (wr_line_addr !== 12'h300 || wr_sel !== 16'h000D) begin
            n_bad++; $display("FAIL merge_entry1 got=%h/%h exp=300/000D", wr_line_addr, wr_sel); end
        n_cmp++; if (wr_data !== 128'h3344_0022) begin n_bad++; $display("FAIL merge_data got=%h exp=33440022", wr_data); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        #1;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL merge_count got=%b exp=0", wr_valid); end
    endtask

    task automatic test_full();
        wr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_store(16'h4000 + 16'(i * 16), 16'(8'hA0 + i), 2'b01);
        st_addr  = 16'h5000;
        wr_ready = 1'b1;
        #1;
        n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL full_new_line_ready got=%b exp=0", st_ready); end
        st_addr = 16'h4035;
        #1;
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL full_tail_line_ready got=%b exp=1", st_ready); end
        st_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_cmp++; if (wr_valid !== 1'b1 || wr_line_addr !== 12'h400 + 12'(i)) begin
                n_bad++; $display("FAIL full_drain_order got=%b/%h exp=1/%h", wr_valid, wr_line_addr, 12'h400 + 12'(i)); end
            tick();
        end
        wr_ready = 1'b0;
        #1;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got=%b exp=0", wr_valid); end
    endtask

    task automatic test_flush();
        int drains;
        bit seen;
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_store(16'h6000 + 16'(i * 16), 16'h0077, 2'b01);
        flush_req = 1'b1;
        wr_ready  = 1'b1;
        drains    = 0;
        seen      = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #1;
            if (c > 0) begin
                n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL flush_st_ready cyc=%0d got=%b exp=0", c, st_ready); end
            end
            if (wr_valid) drains++;
            if (flush_done) seen = 1'b1;
            else begin
                tick();
                flush_req = 1'b0;
            end
        end
        flush_req = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL flush_timeout got=no_done exp=done"); end
        n_cmp++; if (drains != 3) begin n_bad++; $display("FAIL flush_drains got=%0d exp=3", drains); end
        tick();
        #1;
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL flush_done_width got=%b exp=0", flush_done); end
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL flush_resume_ready got=%b exp=1", st_ready); end
        wr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        wr_ready = 1'b0;
        push_store(16'h7000, 16'h0001, 2'b01);
        push_store(16'h7010, 16'h0002, 2'b01);
        wr_ready = 1'b1;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        wr_ready = 1'b0;
        ld_addr  = 16'h7004;
        #1;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr_valid got=%b exp=0", wr_valid); end
        n_cmp++; if (ld_conflict !== 1'b0) begin n_bad++; $display("FAIL rstmid_conflict0 got=%b exp=0", ld_conflict); end
        ld_addr = 16'h7018;
        #1;
        n_cmp++; if (ld_conflict !== 1'b0) begin n_bad++; $display("FAIL rstmid_conflict1 got=%b exp=0", ld_conflict); end
        push_store(16'h8003, 16'h00C3, 2'b01);
        #1;
        n_cmp++; if (wr_line_addr !== 12'h800 || wr_sel !== 16'h0008) begin
            n_bad++; $display("FAIL rstmid_next_store got=%h/%h exp=800/0008", wr_line_addr, wr_sel); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] exp_data;
        logic [1:0]   masks [4];
        masks[0] = 2'b01; masks[1] = 2'b11; masks[2] = 2'b00; masks[3] = 2'b10;
        for (int c = 0; c < 3000; c++) begin
            st_valid  = ($urandom_range(0, 3) != 0);
            st_addr   = {4'h9, 8'h00, 2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            st_data   = 16'($urandom);
            st_wmask  = ($urandom_range(0, 9) == 0) ? masks[$urandom_range(0, 3)] : masks[$urandom_range(0, 1)];
            wr_ready  = ($urandom_range(0, 2) == 0);
            ld_addr   = {4'h9, 8'h00, 2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            flush_req = ($urandom_range(0, 60) == 0);
            rst_n     = ($urandom_range(0, 400) != 0);
            #1;
            n_cmp++; if (st_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_st_ready cyc=%0d got=%b exp=%b", c, st_ready, m_ready()); end
            n_cmp++; if (wr_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rnd_wr_valid cyc=%0d got=%b exp=%b", c, wr_valid, mq.size() > 0); end
            n_cmp++; if (st_err !== m_err) begin n_bad++; $display("FAIL rnd_st_err cyc=%0d got=%b exp=%b", c, st_err, m_err); end
            n_cmp++; if (flush_done !== (m_mode == 2)) begin n_bad++; $display("FAIL rnd_flush_done cyc=%0d got=%b exp=%b", c, flush_done, m_mode == 2); end
            n_cmp++; if (ld_conflict !== m_conflict()) begin n_bad++; $display("FAIL rnd_ld_conflict cyc=%0d got=%b exp=%b", c, ld_conflict, m_conflict()); end
            if (mq.size() > 0) begin
                exp_data = mq[0].bytes;
                n_cmp++; if (wr_line_addr !== mq[0].line || wr_sel !== mq[0].sel || wr_data !== exp_data) begin
                    n_bad++;
                    $display("FAIL rnd_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, wr_line_addr, wr_sel, wr_data, mq[0].line, mq[0].sel, exp_data);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        drive_idle();
    endtask

    initial begin
        m_err  = 1'b0;
        m_mode = 0;
        rst_n  = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_byte_store();
        test_word_store();
        test_merge();
        test_full();
        test_flush();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_merge_buffer.md
Name: store_merge_buffer

Overview:
- Write-combining store buffer between the CPU datapath store port and the cache line write path.
- Accepts byte and word stores and aligns each into a 128-bit line image plus a 16-bit byte-select.
- Coalesces stores to the same line into one entry and drains entries in order to the cache. The cache uses wr_data/wr_sel to merge each entry into the resident line.
- Also reports line conflicts for pending loads.

Parameters:
- DEPTH, 4, number of line entries (power of two, >=2)
- ADDR_W, 16, CPU byte address width
- LINE_BYTES, 16, bytes per cache line (fixed; offset = addr[3:0])

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept the store this cycle
- st_addr  in  ADDR_W  store byte address
- st_data  in  16  store data; byte stores use [7:0]
- st_wmask  in  2  2'b01 = byte store, 2'b11 = word store; other encodings are illegal
- st_err  out  1  one-cycle pulse: illegal store dropped
- wr_valid  out  1  head entry offered to cache
- wr_ready  in  1  cache consumes head entry
- wr_line_addr  out  ADDR_W-4  line address of the head entry
- wr_data  out  128  aligned line image of the head entry
- wr_sel  out  16  byte-select of the head entry
- ld_addr  in  ADDR_W  pending load address
- ld_conflict  out  1  combinational: some valid entry holds ld_addr's line
- flush_req  in  1  request to drain the buffer
- flush_done  out  1  one-cycle pulse: buffer is empty after a flush

Behaviour:
- Reset (rst_n=0 at a clk edge): count=0, head=tail=0, all entry masks cleared, wr_valid=0, st_err=0, flush_done=0, state=RUN. Reset mid-drain or mid-flush discards all entries; no write is offered afterwards.
- Handshakes:
  - A store transfers when st_valid && st_ready.
  - A drain transfers when wr_valid && wr_ready.
  - wr_line_addr, wr_data and wr_sel stay stable while wr_valid=1 and wr_ready=0.
- Alignment, with off = st_addr[3:0]:
  - Byte store: wr byte[off] = st_data[7:0], sel bit off set.
  - Word store: requires st_addr[0]=0. Byte[off] = st_data[7:0], byte[off+1] = st_data[15:8], sel bits off and off+1 set.
  - A word store with st_addr[0]=1, or a wmask of 00 or 10, is accepted (consumed), produces st_err=1 the next cycle, and leaves the buffer unchanged.
- Merge:
  - Condition: tail-1 entry valid, same line, and that entry is not the head (count>=2).
  - Selected bytes overwrite the existing entry bytes and the sel bits are ORed. count is unchanged.
  - Otherwise the store allocates a new entry at tail, with unselected bytes set to 0.
  - The head entry is never modified, so the payload on the cache port stays stable.
- st_ready = (state==RUN) && (count<DEPTH || merge_hit). st_ready may depend combinationally on st_addr.
- Latency: a store accepted at edge N into an empty buffer gives wr_valid=1 in cycle N+1. wr_valid = (count>0). It is registered-state driven, with no combinational path from st_*.
- Simultaneous events:
  - An allocate and a drain in the same cycle leave count unchanged.
  - At count==DEPTH, an allocating store is stalled even if wr_ready=1; a merging store is accepted.
- Pointers wrap modulo DEPTH. count ranges over 0..DEPTH.
- ld_conflict: OR over valid entries of (entry line == ld_addr[ADDR_W-1:4]).
- State machine:
  - RUN -> FLUSH when flush_req=1.
  - FLUSH: st_ready=0; draining continues.
  - FLUSH -> DONE when count==0. An already-empty buffer reaches DONE one cycle after the request.
  - DONE: flush_done=1 for exactly one cycle, then the state returns to RUN.
  - flush_req asserted while in FLUSH or DONE is ignored.

Decomposition:
- Shared package (smb_pkg):
  - Typedef line_entry_t {line_addr, data[127:0], sel[15:0]}.
  - Enum smb_state_t {RUN, FLUSH, DONE}.
  - Constants LINE_BYTES and OFF_W=4.
- One sub-module, store_aligner: purely combinational. Maps (st_addr offset, st_data, st_wmask) to (128-bit image, 16-bit sel, illegal flag). It is reused for the merge and allocate paths.

Test Plan:
- Byte store addr=0x1235, data=0x00AB, wmask=01, wr_ready=1 -> next cycle wr_valid=1, wr_line_addr=0x123, wr_sel=16'h0020, wr_data byte5=0xAB, others 0.
- Word store addr=0x100E, data=0xBEEF -> wr_sel=16'hC000, wr_data[127:112]=0xBEEF. With addr=0x100F, wmask=11 -> st_err pulse, wr_valid stays 0.
- Merge: wr_ready=0; stores 0x2000/0x11 (byte), 0x3000/0x22 (byte), 0x3002/0x3344 (word) -> count=2; entry1 sel=16'h000D, bytes0,2,3 = 22,44,33.
- Full: wr_ready=0; DEPTH stores to 4 distinct lines -> st_ready=0 for a fifth new line, st_ready=1 for the tail line. Raise wr_ready -> entries drain in order, one per cycle.
- Flush: 3 entries, flush_req=1, wr_ready=1 -> st_ready=0 throughout; after 3 drains flush_done pulses one cycle, then st_ready returns to 1.
- Reset mid-drain: 2 entries, rst_n=0 for one edge -> wr_valid=0 and ld_conflict=0 for the old lines; the next store lands at entry 0.
